vga_timing_gen: RTL and testbench

- Source of the raster timing bus (hcount/hsync/hblnk, vcount/vsync/vblnk) that pixel-drawing stages consume.
- Drawing stages compute rgb from this bus and re-register it one stage per block; this block sits at the head of that chain.
- Default timing is 1024x768 @ 60 Hz with a 65 MHz pclk.
- All outputs are registered and mutually aligned; the block adds a one-cycle frame_start strobe and a clock-enable input.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_axis_counter.sv | 61 ++++++
 rtl/vga_timing_gen.sv | 73 +++++++
 tb/tb_vga_timing_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared raster timing constants for the VGA timing generator
package vga_timing_pkg;

    localparam int CNT_W     = 11;
    localparam int CNT_LIMIT = 1 << CNT_W;

    // 1024x768 @ 60 Hz, 65 MHz pixel clock
    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;

    localparam bit SYNC_POL_HIGH = 1'b1;
    localparam bit SYNC_POL_LOW  = 1'b0;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with registered blank/sync decode
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = XGA_H_ACTIVE,
    parameter int FP     = XGA_H_FP,
    parameter int SYNC   = XGA_H_SYNC,
    parameter int BP     = XGA_H_BP
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             blnk,
    output logic             sync_active,
    output logic             wrap
);

    localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_FIRST = ACTIVE + FP;
    localparam int SYNC_LAST  = ACTIVE + FP + SYNC - 1;

    if (TOTAL >= CNT_LIMIT || SYNC < 1 || ACTIVE < 1) begin : g_bad_timing
        $fatal(1, "vga_axis_counter: timing does not fit the counter width");
    end

    logic [CNT_W-1:0] count_q, count_d;
    logic             blnk_q, blnk_d;
    logic             sync_q, sync_d;

    assign wrap = (count_q == CNT_W'(TOTAL - 1));

    // Flags decode the next position so they land on the same edge as the count.
    always_comb begin
        count_d = count_q;
        blnk_d  = blnk_q;
        sync_d  = sync_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + CNT_W'(1);
            blnk_d  = (count_d >= CNT_W'(ACTIVE));
            sync_d  = (count_d >= CNT_W'(SYNC_FIRST)) && (count_d <= CNT_W'(SYNC_LAST));
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            blnk_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            blnk_q  <= blnk_d;
            sync_q  <= sync_d;
        end
    end

    assign count       = count_q;
    assign blnk        = blnk_q;
    assign sync_active = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing bus source with frame_start strobe and count enable
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE         = XGA_H_ACTIVE,
    parameter int H_FP             = XGA_H_FP,
    parameter int H_SYNC           = XGA_H_SYNC,
    parameter int H_BP             = XGA_H_BP,
    parameter int V_ACTIVE         = XGA_V_ACTIVE,
    parameter int V_FP             = XGA_V_FP,
    parameter int V_SYNC           = XGA_V_SYNC,
    parameter int V_BP             = XGA_V_BP,
    parameter bit SYNC_ACTIVE_HIGH = SYNC_POL_HIGH
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcount_out,
    output logic             hsync_out,
    output logic             hblnk_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             vsync_out,
    output logic             vblnk_out,
    output logic             frame_start
);

    logic h_wrap, v_wrap;
    logic h_sync_active, v_sync_active;
    logic v_step;
    logic frame_start_q, frame_start_d;

    assign v_step = en & h_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .pclk        (pclk),
        .rst         (rst),
        .step        (en),
        .count       (hcount_out),
        .blnk        (hblnk_out),
        .sync_active (h_sync_active),
        .wrap        (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .pclk        (pclk),
        .rst         (rst),
        .step        (v_step),
        .count       (vcount_out),
        .blnk        (vblnk_out),
        .sync_active (v_sync_active),
        .wrap        (v_wrap)
    );

    // Next position is (0,0) exactly when both axes wrap on an enabled edge.
    assign frame_start_d = en & h_wrap & v_wrap;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;
    assign hsync_out   = ~(h_sync_active ^ SYNC_ACTIVE_HIGH);
    assign vsync_out   = ~(v_sync_active ^ SYNC_ACTIVE_HIGH);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic        pclk = 1'b0;
    logic        rst_a, en_a, rst_b, en_b;
    logic [10:0] hc_a, vc_a, hc_b, vc_b;
    logic        hs_a, hb_a, vs_a, vb_a, fs_a;
    logic        hs_b, hb_b, vs_b, vb_b, fs_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    vga_timing_gen dut_a (
        .pclk(pclk), .rst(rst_a), .en(en_a),
        .hcount_out(hc_a), .hsync_out(hs_a), .hblnk_out(hb_a),
        .vcount_out(vc_a), .vsync_out(vs_a), .vblnk_out(vb_a),
        .frame_start(fs_a)
    );

    // Small mode: H total 16 (sync 10..12), V total 8 (sync 5..6), inverted sync.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE_HIGH(1'b0)
    ) dut_b (
        .pclk(pclk), .rst(rst_b), .en(en_b),
        .hcount_out(hc_b), .hsync_out(hs_b), .hblnk_out(hb_b),
        .vcount_out(vc_b), .vsync_out(vs_b), .vblnk_out(vb_b),
        .frame_start(fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    int sync_cnt, sync_first, sync_last;
    int fs_cnt, fs_idx, vs_low, hs_low, vb_cnt, hb_cnt, vs_vmin, vs_vmax;

    initial begin
        rst_a = 1'b0; en_a = 1'b1;
        rst_b = 1'b0; en_b = 1'b1;
        step(5);
        chk("rst_hcount", hc_a, 0);
        chk("rst_vcount", vc_a, 0);
        chk("rst_hsync", hs_a, 0);
        chk("rst_vsync", vs_a, 0);
        chk("rst_hblnk", hb_a, 0);
        chk("rst_vblnk", vb_a, 0);
        chk("rst_fs", fs_a, 0);

        rst_a = 1'b1;
        step(1);
        chk("first_edge_h", hc_a, 1);

        step(1022);
        chk("h1023_h", hc_a, 1023);
        chk("h1023_hblnk", hb_a, 0);
        step(1);
        chk("hblnk_rise_h", hc_a, 1024);
        chk("hblnk_rise", hb_a, 1);

        sync_cnt = 0; sync_first = -1; sync_last = -1;
        for (int i = 0; i < 320; i++) begin
            if (hs_a) begin
                sync_cnt++;
                if (sync_first < 0) sync_first = int'(hc_a);
                sync_last = int'(hc_a);
            end
            step(1);
        end
        chk("hsync_width", sync_cnt, 136);
        chk("hsync_first", sync_first, 1048);
        chk("hsync_last", sync_last, 1183);
        chk("line_wrap_h", hc_a, 0);
        chk("line_wrap_v", vc_a, 1);
        chk("hblnk_fall", hb_a, 0);

        step(9 * 1344 + 1343);
        chk("pre_wrap_h", hc_a, 1343);
        chk("pre_wrap_v", vc_a, 10);
        step(1);
        chk("wrap10_h", hc_a, 0);
        chk("wrap10_v", vc_a, 11);
        chk("wrap10_fs", fs_a, 0);

        step(1047);
        chk("pre_hold_h", hc_a, 1047);
        chk("pre_hold_hsync", hs_a, 0);
        en_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("hold_h", hc_a, 1047);
            chk("hold_v", vc_a, 11);
            chk("hold_hsync", hs_a, 0);
            chk("hold_hblnk", hb_a, 1);
            chk("hold_fs", fs_a, 0);
        end
        en_a = 1'b1;
        step(1);
        chk("resume_h", hc_a, 1048);
        chk("resume_hsync", hs_a, 1);

        step(296 + 500);
        chk("pre_areset_h", hc_a, 500);
        chk("pre_areset_v", vc_a, 12);
        #2 rst_a = 1'b0;
        #1;
        chk("areset_h", hc_a, 0);
        chk("areset_v", vc_a, 0);
        chk("areset_hblnk", hb_a, 0);
        chk("areset_hsync", hs_a, 0);
        chk("areset_fs", fs_a, 0);
        step(2);
        rst_a = 1'b1;
        step(1);
        chk("rerelease_h", hc_a, 1);
        chk("rerelease_v", vc_a, 0);
        chk("rerelease_fs", fs_a, 0);

        chk("b_rst_hsync", hs_b, 1);
        chk("b_rst_vsync", vs_b, 1);
        chk("b_rst_h", hc_b, 0);
        chk("b_rst_fs", fs_b, 0);
        rst_b = 1'b1;
        step(127);
        chk("b_prewrap_h", hc_b, 15);
        chk("b_prewrap_v", vc_b, 7);
        chk("b_prewrap_vblnk", vb_b, 1);
        chk("b_prewrap_fs", fs_b, 0);
        step(1);
        chk("b_wrap_h", hc_b, 0);
        chk("b_wrap_v", vc_b, 0);
        chk("b_wrap_fs", fs_b, 1);
        chk("b_wrap_vblnk", vb_b, 0);
        en_b = 1'b0;
        step(1);
        chk("b_hold_fs", fs_b, 0);
        chk("b_hold_h", hc_b, 0);
        en_b = 1'b1;

        fs_cnt = 0; fs_idx = -1; vs_low = 0; hs_low = 0; vb_cnt = 0; hb_cnt = 0;
        vs_vmin = 99; vs_vmax = -1;
        for (int i = 1; i <= 128; i++) begin
            step(1);
            if (fs_b) begin fs_cnt++; fs_idx = i; end
            if (!vs_b) begin
                vs_low++;
                if (int'(vc_b) < vs_vmin) vs_vmin = int'(vc_b);
                if (int'(vc_b) > vs_vmax) vs_vmax = int'(vc_b);
            end
            if (!hs_b) hs_low++;
            if (vb_b) vb_cnt++;
            if (hb_b) hb_cnt++;
        end
        chk("b_fs_count", fs_cnt, 1);
        chk("b_fs_period", fs_idx, 128);
        chk("b_vsync_low", vs_low, 32);
        chk("b_vsync_vmin", vs_vmin, 5);
        chk("b_vsync_vmax", vs_vmax, 6);
        chk("b_hsync_low", hs_low, 24);
        chk("b_vblnk", vb_cnt, 64);
        chk("b_hblnk", hb_cnt, 64);
        step(1);
        chk("b_post_fs", fs_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
